// File: rtl/angle_tracking_unit.sv
// ============================================================================
// Module   : angle_tracking_unit
// Brief    : Quadrature-encoder decoder producing a wrapping absolute angle.
//            Optional index-zeroing is enabled by defining ATU_INDEX_ZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module angle_tracking_unit #(
    parameter int ANGLE_W        = 12,
    parameter int COUNTS_PER_REV = 4096,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               enc_index,
    input  logic               atu_reset,
    input  logic               atu_monitor,
    output logic [ANGLE_W-1:0] current_angle,
    output logic               direction,
    output logic               step_pulse,
    output logic               quad_error
);

    localparam logic [ANGLE_W-1:0] c_angle_max   = ANGLE_W'(COUNTS_PER_REV - 1);
    localparam int                 SETTLE_W      = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] c_settle_done = SETTLE_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic [1:0]             prev_ab_q;
    logic [SETTLE_W-1:0]    settle_q;
    logic [ANGLE_W-1:0]     angle_q, angle_d;
    logic                   dir_q, dir_d;
    logic                   step_q, step_d;
    logic                   err_q, err_d;

    logic [1:0]             w_ab;
    logic [1:0]             w_pos;
    logic [1:0]             w_prev_pos;
    logic [1:0]             w_delta;
    logic                   w_settled;
    logic                   w_index_rise;
    logic [ANGLE_W-1:0]     w_angle_inc;
    logic [ANGLE_W-1:0]     w_angle_dec;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a_sync_q  <= '0;
            b_sync_q  <= '0;
            prev_ab_q <= 2'b00;
            settle_q  <= '0;
        end else begin
            a_sync_q  <= {a_sync_q[SYNC_STAGES-2:0], enc_a};
            b_sync_q  <= {b_sync_q[SYNC_STAGES-2:0], enc_b};
            prev_ab_q <= w_ab;
            if (settle_q != c_settle_done) begin
                settle_q <= settle_q + 1'b1;
            end
        end
    end

`ifdef ATU_INDEX_ZERO_EN
    logic [SYNC_STAGES-1:0] idx_sync_q;
    logic                   idx_prev_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            idx_sync_q <= '0;
            idx_prev_q <= 1'b0;
        end else begin
            idx_sync_q <= {idx_sync_q[SYNC_STAGES-2:0], enc_index};
            idx_prev_q <= idx_sync_q[SYNC_STAGES-1];
        end
    end

    assign w_index_rise = idx_sync_q[SYNC_STAGES-1] & ~idx_prev_q;
`else
    logic w_index_unused;
    assign w_index_unused = enc_index;
    assign w_index_rise   = 1'b0;
`endif

    // Map Gray-coded AB onto a 0..3 phase so direction is a simple difference.
    assign w_ab        = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    assign w_pos       = {w_ab[1], w_ab[1] ^ w_ab[0]};
    assign w_prev_pos  = {prev_ab_q[1], prev_ab_q[1] ^ prev_ab_q[0]};
    assign w_delta     = w_pos - w_prev_pos;
    assign w_settled   = (settle_q == c_settle_done);
    assign w_angle_inc = (angle_q == c_angle_max) ? '0 : angle_q + 1'b1;
    assign w_angle_dec = (angle_q == '0) ? c_angle_max : angle_q - 1'b1;

    always_comb begin
        angle_d = angle_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;
        if (w_settled) begin
            if (w_delta == 2'd2) begin
                err_d = 1'b1;
            end else if (atu_monitor && (w_delta == 2'd1)) begin
                angle_d = w_angle_inc;
                dir_d   = 1'b1;
                step_d  = 1'b1;
            end else if (atu_monitor && (w_delta == 2'd3)) begin
                angle_d = w_angle_dec;
                dir_d   = 1'b0;
                step_d  = 1'b1;
            end
            if (w_index_rise && atu_monitor) begin
                angle_d = '0;
            end
        end
        // Controller clear overrides any step, error or index event.
        if (atu_reset) begin
            angle_d = '0;
            err_d   = 1'b0;
            step_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            angle_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            angle_q <= angle_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign current_angle = angle_q;
    assign direction     = dir_q;
    assign step_pulse    = step_q;
    assign quad_error    = err_q;

endmodule

`default_nettype wire
